flash_boot_copier: RTL and testbench

Bus initiator that copies a boot image from the on-board flash into RAM at power-up or on request. It issues read transactions to the flash bus slave, which returns one 16-bit halfword per access in data bits [15:0]. It packs each pair of halfwords into a 32-bit word and writes that word to the RAM bus slave. It sits on the same shared bus as the CPU data port, behind the arbiter, and holds the CPU in stall via `busy_o` until the copy finishes.

---
 rtl/flash_boot_copier_if.sv | 20 ++
 rtl/flash_boot_copier.sv | 184 ++++++++++++++++++
 tb/tb_flash_boot_copier.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/flash_boot_copier_if.sv
// Shared-bus port bundle for the flash boot copier: single-beat select/ack
// transactions, driven by the copier (master) toward flash/RAM slaves.
interface flash_boot_copier_if;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic        bus_select_o;
  logic        bus_we_o;
  logic        bus_ack_i;

  modport master (
    output bus_addr_o, bus_data_o, bus_select_o, bus_we_o,
    input  bus_data_i, bus_ack_i
  );

  modport slave (
    input  bus_addr_o, bus_data_o, bus_select_o, bus_we_o,
    output bus_data_i, bus_ack_i
  );
endinterface

// File: rtl/flash_boot_copier.sv
// Copies WORDS 32-bit words from 16-bit flash (two halfword reads) into RAM.
// Optional ack timeout enabled by defining FLASH_BOOT_TIMEOUT_EN.
module flash_boot_copier #(
  parameter logic [31:0] FLASH_BASE = 32'h1E00_0000,
  parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
  parameter int          WORDS      = 1024,
  parameter int          TIMEOUT    = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  flash_boot_copier_if.master        bus,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       error_o
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR, GAP, FIN, ERR} state_t;

  localparam logic [1:0]  RET_LO = 2'd0;
  localparam logic [1:0]  RET_HI = 2'd1;
  localparam logic [1:0]  RET_WR = 2'd2;
  localparam logic [15:0] LAST   = 16'(WORDS - 1);

  state_t      state_q, state_d;
  logic [1:0]  ret_q, ret_d;
  logic [15:0] n_q, n_d, lo_q, lo_d, hi_q, hi_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        sel_q, sel_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic        acc_ok, tmo_hit;

  assign acc_ok = sel_q & bus.bus_ack_i;

`ifdef FLASH_BOOT_TIMEOUT_EN
  localparam logic [15:0] TMO = 16'(TIMEOUT);
  logic [15:0] wcnt_q, wcnt_d;
  logic        err_q, err_d;

  assign tmo_hit = sel_q & ~bus.bus_ack_i & (wcnt_q == TMO);
  assign error_o = err_q;
`else
  assign tmo_hit = 1'b0;
  assign error_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    n_d     = n_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    done_d  = done_q;
`ifdef FLASH_BOOT_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: if (start_i) begin
        done_d = 1'b0;
`ifdef FLASH_BOOT_TIMEOUT_EN
        err_d  = 1'b0;
`endif
        n_d    = '0;
        // Enter through GAP so the first read appears one edge after start.
        if (WORDS == 0) state_d = FIN;
        else begin
          state_d = GAP;
          ret_d   = RET_LO;
        end
      end
      RD_LO: begin
        if (tmo_hit) state_d = ERR;
        else if (acc_ok) begin
          lo_d    = bus.bus_data_i[15:0];
          state_d = GAP;
          ret_d   = RET_HI;
        end
      end
      RD_HI: begin
        if (tmo_hit) state_d = ERR;
        else if (acc_ok) begin
          hi_d    = bus.bus_data_i[15:0];
          state_d = GAP;
          ret_d   = RET_WR;
        end
      end
      WR: begin
        if (tmo_hit) state_d = ERR;
        else if (acc_ok) begin
          if (n_q == LAST) state_d = FIN;
          else begin
            n_d     = n_q + 16'd1;
            state_d = GAP;
            ret_d   = RET_LO;
          end
        end
      end
      GAP: begin
        case (ret_q)
          RET_HI:  state_d = RD_HI;
          RET_WR:  state_d = WR;
          default: state_d = RD_LO;
        endcase
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
`ifdef FLASH_BOOT_TIMEOUT_EN
        err_d   = 1'b1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered from the next state, so they hold steady
    // for as long as the state waits on ack.
    sel_d  = (state_d == RD_LO) || (state_d == RD_HI) || (state_d == WR);
    we_d   = (state_d == WR);
    busy_d = sel_d || (state_d == GAP);
    case (state_d)
      RD_LO:   addr_d = FLASH_BASE + {13'b0, n_d, 3'b0};
      RD_HI:   addr_d = FLASH_BASE + {13'b0, n_d, 3'b0} + 32'd4;
      WR:      addr_d = RAM_BASE + {14'b0, n_d, 2'b0};
      default: addr_d = '0;
    endcase
    wdata_d = we_d ? {hi_d, lo_d} : 32'h0;
  end

`ifdef FLASH_BOOT_TIMEOUT_EN
  always_comb begin
    wcnt_d = wcnt_q;
    if (sel_d && !sel_q)                 wcnt_d = '0;
    else if (sel_q && !bus.bus_ack_i)    wcnt_d = wcnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ret_q   <= RET_LO;
      n_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      n_q     <= n_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.bus_addr_o   = addr_q;
  assign bus.bus_data_o   = wdata_q;
  assign bus.bus_select_o = sel_q;
  assign bus.bus_we_o     = we_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_flash_boot_copier.sv
// Directed + randomized bench for flash_boot_copier: flash/RAM slave model with
// random ack latency, transaction log checked against an expected copy list.
module tb_flash_boot_copier;
  localparam logic [31:0] FB = 32'h1E00_0000;
  localparam logic [31:0] RB = 32'h2000_0040;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start0 = 1'b0;
  logic busy, done, err, busy0, done0, err0;

  flash_boot_copier_if bus();
  flash_boot_copier_if bus0();

  flash_boot_copier #(.FLASH_BASE(FB), .RAM_BASE(RB), .WORDS(2), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .start_i(start), .bus(bus),
    .busy_o(busy), .done_o(done), .error_o(err));

  flash_boot_copier #(.FLASH_BASE(FB), .RAM_BASE(RB), .WORDS(0), .TIMEOUT(20)) dut0 (
    .clk(clk), .rst(rst), .start_i(start0), .bus(bus0),
    .busy_o(busy0), .done_o(done0), .error_o(err0));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    int          cyc;
  } txn_t;

  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, lat = 0, sel0_cnt = 0;
  bit   fixed_lat = 1'b1, noack = 1'b0;
  logic [15:0] flash_mem [0:3];
  txn_t log_q[$];
  int   sel_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] flash_rd(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - FB) >> 2;
    return (idx < 4) ? flash_mem[idx[1:0]] : 16'hDEAD;
  endfunction

  // Slave: acks after cur_lat waiting cycles, logs every completed access.
  initial begin
    int wc, cur_lat;
    logic [31:0] r;
    txn_t t;
    wc = 0; cur_lat = 0;
    bus.bus_ack_i = 1'b0; bus.bus_data_i = '0;
    bus0.bus_ack_i = 1'b0; bus0.bus_data_i = '0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.bus_ack_i = 1'b0;
      r = $urandom;
      bus.bus_data_i = r;
      if (bus0.bus_select_o) sel0_cnt++;
      if (rst || !bus.bus_select_o) begin
        wc = 0;
        cur_lat = fixed_lat ? lat : int'($urandom_range(0, 3));
      end else begin
        sel_cyc.push_back(cyc);
        if (!noack) begin
          if (wc >= cur_lat) begin
            bus.bus_ack_i = 1'b1;
            if (!bus.bus_we_o) bus.bus_data_i = {r[31:16], flash_rd(bus.bus_addr_o)};
            t = '{bus.bus_addr_o, bus.bus_we_o, bus.bus_data_o, cyc};
            log_q.push_back(t);
            wc = 0;
          end else wc++;
        end
      end
    end
  end

  task automatic pulse_start();
    log_q.delete();
    sel_cyc.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!(done && !busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_wait"}, 32'(k < 200), 32'd1);
  endtask

  // Expected copy: word w reads FB+8w, FB+8w+4, writes RB+4w = {hi, lo}.
  task automatic check_log(input string tag);
    logic [31:0] ea, ed;
    check({tag, "_ntxn"}, 32'(log_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      int w, t;
      w = i / 3; t = i % 3;
      ea = (t == 0) ? FB + 32'(8 * w) : (t == 1) ? FB + 32'(8 * w + 4) : RB + 32'(4 * w);
      ed = (t == 2) ? {flash_mem[2 * w + 1], flash_mem[2 * w]} : 32'h0;
      check($sformatf("%s_addr%0d", tag, i), log_q[i].addr, ea);
      check($sformatf("%s_we%0d", tag, i), 32'(log_q[i].we), 32'(t == 2));
      check($sformatf("%s_data%0d", tag, i), log_q[i].data, ed);
    end
  endtask

  initial begin
    int k, span;
    bit ok;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_sel", 32'(bus.bus_select_o), 32'd0);
    check("rst_addr", bus.bus_addr_o, 32'd0);
    check("rst_data", bus.bus_data_o, 32'd0);
    check("rst_we", 32'(bus.bus_we_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_done0", 32'(done0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic copy, 3-cycle ack latency
    flash_mem[0] = 16'h1111; flash_mem[1] = 16'h2222;
    flash_mem[2] = 16'h3333; flash_mem[3] = 16'h4444;
    fixed_lat = 1'b1; lat = 3;
    pulse_start();
    check("start_sel_k", 32'(bus.bus_select_o), 32'd0);
    check("start_busy_k", 32'(busy), 32'd1);
    @(negedge clk);
    check("start_sel_k1", 32'(bus.bus_select_o), 32'd1);
    check("start_addr_k1", bus.bus_addr_o, FB);
    wait_done("basic");
    check_log("basic");
    check("basic_done", 32'(done), 32'd1);
    check("basic_busy", 32'(busy), 32'd0);

    // GAP / throughput with single-cycle ack
    lat = 0;
    pulse_start();
    wait_done("gap");
    check_log("gap");
    check("gap_highs", 32'(sel_cyc.size()), 32'd6);
    ok = 1'b1;
    for (int i = 1; i < sel_cyc.size(); i++) if (sel_cyc[i] - sel_cyc[i - 1] != 2) ok = 1'b0;
    check("gap_one_low", 32'(ok), 32'd1);
    span = (sel_cyc.size() > 0 && log_q.size() == 6) ? log_q[5].cyc - sel_cyc[0] + 1 : -1;
    check("gap_span", 32'(span), 32'd11);

    // Randomized contents and latencies
    fixed_lat = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) flash_mem[i] = 16'($urandom);
      pulse_start();
      wait_done($sformatf("rnd%0d", r));
      check_log($sformatf("rnd%0d", r));
    end

    // Start while busy is ignored
    pulse_start();
    repeat (3) @(negedge clk);
    check("restart_busy", 32'(busy), 32'd1);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done("restart");
    check_log("restart");
    pulse_start();
    check("restart_done_clr", 32'(done), 32'd0);
    wait_done("restart2");
    check_log("restart2");

    // Zero-length copy on the second instance
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("zero_done_k", 32'(done0), 32'd0);
    @(negedge clk);
    check("zero_done_k1", 32'(done0), 32'd1);
    check("zero_busy", 32'(busy0), 32'd0);
    check("zero_nosel", 32'(sel0_cnt), 32'd0);

    // Reset while RD_HI is on the bus
    fixed_lat = 1'b1; lat = 5;
    pulse_start();
    k = 0;
    while (!(bus.bus_select_o && bus.bus_addr_o == FB + 32'd4) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rsthi_reached", 32'(k < 100), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rsthi_sel", 32'(bus.bus_select_o), 32'd0);
    check("rsthi_addr", bus.bus_addr_o, 32'd0);
    check("rsthi_we", 32'(bus.bus_we_o), 32'd0);
    check("rsthi_busy", 32'(busy), 32'd0);
    check("rsthi_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    lat = 0;
    pulse_start();
    wait_done("rsthi_again");
    check_log("rsthi_again");

`ifdef FLASH_BOOT_TIMEOUT_EN
    // Slave never acks
    noack = 1'b1;
    pulse_start();
    k = 0;
    while (!bus.bus_select_o && k < 10) begin @(negedge clk); k++; end
    k = 0;
    while (bus.bus_select_o && k < 100) begin @(negedge clk); k++; end
    check("tmo_edges", 32'(k), 32'd21);
    repeat (2) @(negedge clk);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_done", 32'(done), 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);
    noack = 1'b0;
`else
    check("err_tied", 32'(err), 32'd0);
    check("err0_tied", 32'(err0), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
